// File: rtl/slave_package.sv
// rtl/slave_package.sv - AHB transfer encodings, FSM states and size helper for the SRAM slave
package slave_package;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } HTRANS_E;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3,
      HSIZE_4W    = 3'd4,
      HSIZE_8W    = 3'd5,
      HSIZE_16W   = 3'd6,
      HSIZE_32W   = 3'd7
   } HSIZE_E;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } HBURST_E;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } HRESP_E;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_e;

   // Number of bytes moved by one beat of the given size (1..128).
   function automatic logic [7:0] size_bytes(input HSIZE_E s);
      return 8'd1 << s;
   endfunction

endpackage

// File: rtl/sram_lanes.sv
// rtl/sram_lanes.sv - byte-lane SRAM array with per-lane write enables and combinational read
module sram_lanes #(
   parameter int LANES = 4,
   parameter int ROWS = 256,
   localparam int ROW_W = $clog2(ROWS)
) (
   input  logic               HCLK,
   input  logic [LANES-1:0]   lane_we,
   input  logic [ROW_W-1:0]   row,
   input  logic [LANES*8-1:0] wdata,
   output logic [LANES*8-1:0] rdata
);

   // Each lane owns its own byte-wide array so lane writes never share a storage element.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] mem [ROWS];

      // Byte write on this lane when its enable is set; contents are never reset.
      always_ff @(posedge HCLK) begin
         if (lane_we[l]) begin
            mem[row] <= wdata[8*l +: 8];
         end
      end

      assign rdata[8*l +: 8] = mem[row];
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR response
module ahb_sram_slave
   import slave_package::*;
#(
   parameter int DATA_W = 32,
   parameter int MEM_BYTES = 1024,
   parameter int WAIT_STATES = 0,
   parameter int ERR_UNALIGNED = 1
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  HTRANS_E           HTRANS,
   input  logic              HWRITE,
   input  HSIZE_E            HSIZE,
   input  HBURST_E           HBURST,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output HRESP_E            HRESP,
   output logic [DATA_W-1:0] HRDATA
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(MEM_BYTES);
   localparam int LANE_W = $clog2(LANES);
   localparam int ROWS = MEM_BYTES / LANES;
   localparam logic [7:0] LANES_B = 8'(LANES);

   // Registered data-phase state
   state_e           state, state_nx;
   logic [3:0]       cnt, cnt_nx;
   logic             dp_valid, dp_valid_nx;
   logic             dp_write, dp_write_nx;
   logic [OFF_W-1:0] dp_offset, dp_offset_nx;
   HSIZE_E           dp_size, dp_size_nx;

   // Address-phase decode
   logic             addr_ok;
   logic [7:0]       req_bytes;
   logic             size_err;
   logic             misalign;
   logic [3:0]       wait_cnt;

   // Data-phase response before the reset override
   logic             ready;
   HRESP_E           resp;

   // Memory side
   logic [LANES-1:0]  lane_en;
   logic [DATA_W-1:0] lane_bits;
   logic [LANES-1:0]  lane_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              wr_go;
   logic              rd_go;

   // Burst type and the address bits above the memory size carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HADDR[31:OFF_W]};

   assign addr_ok   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign req_bytes = size_bytes(HSIZE);
   assign size_err  = (req_bytes > LANES_B);
   assign misalign  = (ERR_UNALIGNED != 0) && ((HADDR[7:0] & (req_bytes - 8'd1)) != 8'd0);
   // SEQ beats are page-mode hits and never stall.
   assign wait_cnt  = (HTRANS == HTRANS_NONSEQ) ? 4'(WAIT_STATES) : 4'd0;

   // Phase state register; memory contents are deliberately left alone by reset.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_offset <= '0;
         dp_size   <= HSIZE_BYTE;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         dp_valid  <= dp_valid_nx;
         dp_write  <= dp_write_nx;
         dp_offset <= dp_offset_nx;
         dp_size   <= dp_size_nx;
      end
   end

   // Response for the current data phase and the next state, including pipelined acceptance.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      dp_valid_nx  = dp_valid;
      dp_write_nx  = dp_write;
      dp_offset_nx = dp_offset;
      dp_size_nx   = dp_size;
      ready        = 1'b1;
      resp         = HRESP_OKAY;

      case (state)
         ST_WAIT: ready = (cnt == 4'd0);
         ST_ERR1: begin
            ready = 1'b0;
            resp  = HRESP_ERROR;
         end
         ST_ERR2: resp = HRESP_ERROR;
         default: ;
      endcase

      if (state == ST_WAIT && cnt != 4'd0) begin
         cnt_nx = cnt - 4'd1;
      end else if (state == ST_ERR1) begin
         state_nx = ST_ERR2;
      end else begin
         // Completing cycle: the current data phase ends and a new address phase may start.
         state_nx    = ST_IDLE;
         cnt_nx      = 4'd0;
         dp_valid_nx = 1'b0;
         if (addr_ok) begin
            dp_offset_nx = HADDR[OFF_W-1:0];
            dp_size_nx   = HSIZE;
            dp_write_nx  = HWRITE;
            if (size_err || misalign) begin
               state_nx = ST_ERR1;
            end else begin
               dp_valid_nx = 1'b1;
               if (wait_cnt != 4'd0) begin
                  state_nx = ST_WAIT;
                  cnt_nx   = wait_cnt;
               end
            end
         end
      end
   end

   // Lanes touched by the registered transfer, little-endian from the offset's lane.
   always_comb begin
      lane_en   = '0;
      lane_bits = '0;
      for (int l = 0; l < LANES; l++) begin
         if (l >= int'(dp_offset[LANE_W-1:0]) &&
             l < int'(dp_offset[LANE_W-1:0]) + int'(size_bytes(dp_size))) begin
            lane_en[l]         = 1'b1;
            lane_bits[8*l +: 8] = 8'hFF;
         end
      end
   end

   assign wr_go   = !HRESET && ready && dp_valid && dp_write;
   assign rd_go   = !HRESET && ready && dp_valid && !dp_write;
   assign lane_we = lane_en & {LANES{wr_go}};

   sram_lanes #(
      .LANES (LANES),
      .ROWS  (ROWS)
   ) u_lanes (
      .HCLK    (HCLK),
      .lane_we (lane_we),
      .row     (dp_offset[OFF_W-1:LANE_W]),
      .wdata   (HWDATA),
      .rdata   (mem_rdata)
   );

   assign HREADYOUT = HRESET ? 1'b1 : ready;
   assign HRESP     = HRESET ? HRESP_OKAY : resp;
   assign HRDATA    = rd_go ? (mem_rdata & lane_bits) : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;
   import slave_package::*;

   logic HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   logic        HRESET;
   logic [1:0]  hsel;
   logic [31:0] haddr;
   HTRANS_E     htrans;
   logic        hwrite;
   HSIZE_E      hsize;
   HBURST_E     hburst;
   logic [31:0] hwdata;
   logic [1:0]  hready;
   HRESP_E      hresp0, hresp1;
   logic [31:0] hrdata0, hrdata1;

   int checks = 0;
   int passed = 0;

   ahb_sram_slave #(.DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(0), .ERR_UNALIGNED(1)) u_dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready[0]),
      .HREADYOUT(hready[0]), .HRESP(hresp0), .HRDATA(hrdata0));

   ahb_sram_slave #(.DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(2), .ERR_UNALIGNED(1)) u_dut1 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready[1]),
      .HREADYOUT(hready[1]), .HRESP(hresp1), .HRDATA(hrdata1));

   typedef struct {
      logic        wr;
      HSIZE_E      sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   localparam int P_NONE = 0;
   localparam int P_OK   = 1;
   localparam int P_ERR1 = 2;
   localparam int P_ERR2 = 3;

   logic [7:0]  mm [64];
   logic [31:0] bmem [4];
   logic [31:0] rd, exp_rd, r_wd, p_wd, d;
   logic        ea, en, hold, p_wr, exp_rdy, exp_e;
   int          waits, issued, done, cycles, pk, p_off, p_nb, r_off, nb;
   logic [7:0]  pat;

   function automatic logic rdy(input int t);
      return (t == 0) ? hready[0] : hready[1];
   endfunction

   function automatic logic is_err(input int t);
      return (t == 0) ? (hresp0 == HRESP_ERROR) : (hresp1 == HRESP_ERROR);
   endfunction

   function automatic logic [31:0] rdat(input int t);
      return (t == 0) ? hrdata0 : hrdata1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      $display("FAIL %s: HREADYOUT never rose within the cycle bound", name);
   endtask

   task automatic idle_bus();
      hsel   = 2'b00;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
      hsize  = HSIZE_WORD;
      haddr  = 32'h0;
      hburst = HBURST_SINGLE;
   endtask

   // One non-pipelined transfer; entered and left just after a rising edge.
   task automatic xfer(input int t, input logic wr, input HSIZE_E sz, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdo, output int nwait,
                       output logic err_all, output logic err_any);
      int n;
      hsel   = 2'b01 << t;
      htrans = HTRANS_NONSEQ;
      hwrite = wr;
      hsize  = sz;
      haddr  = addr;
      hburst = HBURST_SINGLE;
      n = 0;
      @(negedge HCLK);
      while (!rdy(t) && n < 40) begin
         @(negedge HCLK);
         n++;
      end
      if (n >= 40) timeout_fail("xfer_addr");
      @(posedge HCLK);
      #1;
      idle_bus();
      hwdata  = wd;
      nwait   = 0;
      err_all = 1'b1;
      err_any = 1'b0;
      @(negedge HCLK);
      while (1) begin
         err_all = err_all & is_err(t);
         err_any = err_any | is_err(t);
         if (rdy(t)) break;
         nwait++;
         if (nwait > 40) begin
            timeout_fail("xfer_data");
            break;
         end
         @(negedge HCLK);
      end
      rdo = rdat(t);
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset with a live-looking address phase on the bus.
      HRESET = 1'b1;
      hsel   = 2'b11;
      htrans = HTRANS_NONSEQ;
      hwrite = 1'b0;
      hsize  = HSIZE_WORD;
      haddr  = 32'h10;
      hburst = HBURST_SINGLE;
      hwdata = 32'h0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      for (int t = 0; t < 2; t++) begin
         chk($sformatf("reset_ready%0d", t), 32'(rdy(t)), 32'd1);
         chk($sformatf("reset_resp%0d", t), 32'(is_err(t)), 32'd0);
         chk($sformatf("reset_rdata%0d", t), rdat(t), 32'h0);
      end
      @(posedge HCLK);
      #1;
      idle_bus();
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;

      // Directed single transfers on the zero-wait instance.
      tbl.push_back('{1'b1, HSIZE_WORD,  32'h0000_0000, 32'h1122_3344, 32'h0,          1'b0});
      tbl.push_back('{1'b1, HSIZE_WORD,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
      tbl.push_back('{1'b1, HSIZE_BYTE,  32'h0000_0013, 32'hAA12_3456, 32'h0,          1'b0});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         32'hAAAD_BEEF, 1'b0});
      tbl.push_back('{1'b0, HSIZE_HALF,  32'h0000_0012, 32'h0,         32'hAAAD_0000, 1'b0});
      tbl.push_back('{1'b0, HSIZE_BYTE,  32'h0000_0013, 32'h0,         32'hAA00_0000, 1'b0});
      tbl.push_back('{1'b0, HSIZE_BYTE,  32'h0000_0010, 32'h0,         32'h0000_00EF, 1'b0});
      tbl.push_back('{1'b1, HSIZE_HALF,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0,          1'b1});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0000, 32'h0,         32'h1122_3344, 1'b0});
      tbl.push_back('{1'b1, HSIZE_WORD,  32'h0000_0002, 32'hFFFF_FFFF, 32'h0,          1'b1});
      tbl.push_back('{1'b1, HSIZE_DWORD, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0,          1'b1});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0000, 32'h0,         32'h1122_3344, 1'b0});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0410, 32'h0,         32'hAAAD_BEEF, 1'b0});
      tbl.push_back('{1'b1, HSIZE_HALF,  32'hFFFF_F402, 32'h7788_0000, 32'h0,          1'b0});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0000, 32'h0,         32'h7788_3344, 1'b0});
      tbl.push_back('{1'b0, HSIZE_HALF,  32'h0000_0000, 32'h0,         32'h0000_3344, 1'b0});
      tbl.push_back('{1'b1, HSIZE_BYTE,  32'h0000_0011, 32'h0000_6600, 32'h0,          1'b0});
      tbl.push_back('{1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         32'hAAAD_66EF, 1'b0});

      foreach (tbl[i]) begin
         xfer(0, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wd, rd, waits, ea, en);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_waits", i), 32'(waits), tbl[i].exp_err ? 32'd1 : 32'd0);
         if (tbl[i].exp_err) chk($sformatf("tbl%0d_err_both", i), 32'(ea), 32'd1);
         else                chk($sformatf("tbl%0d_okay", i), 32'(en), 32'd0);
      end

      // INCR4 read on the two-wait-state instance.
      for (int i = 0; i < 4; i++) begin
         bmem[i] = 32'hA0B0_0000 + 32'(i * 32'h101);
         xfer(1, 1'b1, HSIZE_WORD, 32'h20 + 32'(4 * i), bmem[i], rd, waits, ea, en);
         chk($sformatf("preload%0d_waits", i), 32'(waits), 32'd2);
      end
      hsel   = 2'b10;
      hwrite = 1'b0;
      hsize  = HSIZE_WORD;
      hburst = HBURST_INCR4;
      htrans = HTRANS_NONSEQ;
      haddr  = 32'h20;
      @(negedge HCLK);
      @(posedge HCLK);
      #1;
      issued = 1;
      done   = 0;
      cycles = 1;
      pat    = 8'h0;
      while (done < 4 && cycles < 40) begin
         if (issued < 4) begin
            htrans = HTRANS_SEQ;
            haddr  = 32'h20 + 32'(4 * issued);
         end else begin
            hsel   = 2'b00;
            htrans = HTRANS_IDLE;
         end
         @(negedge HCLK);
         cycles++;
         pat = {pat[6:0], rdy(1)};
         if (rdy(1)) begin
            chk($sformatf("burst%0d_rdata", done), rdat(1), bmem[done]);
            chk($sformatf("burst%0d_resp", done), 32'(is_err(1)), 32'd0);
            done++;
            if (issued < 4) issued++;
         end
         @(posedge HCLK);
         #1;
      end
      if (done < 4) timeout_fail("burst");
      chk("burst_cycles", 32'(cycles), 32'd7);
      chk("burst_ready_pattern", 32'(pat), 32'h0F);
      idle_bus();

      // Reset landing on the completing cycle of a waited write must cancel it.
      xfer(1, 1'b1, HSIZE_WORD, 32'h40, 32'h1122_3344, rd, waits, ea, en);
      chk("rst_pre_waits", 32'(waits), 32'd2);
      hsel   = 2'b10;
      htrans = HTRANS_NONSEQ;
      hwrite = 1'b1;
      hsize  = HSIZE_WORD;
      haddr  = 32'h40;
      @(posedge HCLK);
      #1;
      idle_bus();
      hwdata = 32'h5566_7788;
      @(negedge HCLK);
      chk("rst_wait1_ready", 32'(rdy(1)), 32'd0);
      @(posedge HCLK);
      #1;
      @(negedge HCLK);
      chk("rst_wait2_ready", 32'(rdy(1)), 32'd0);
      @(posedge HCLK);
      #1;
      HRESET = 1'b1;
      @(negedge HCLK);
      chk("rst_during_ready", 32'(rdy(1)), 32'd1);
      chk("rst_during_resp", 32'(is_err(1)), 32'd0);
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      chk("rst_after_ready", 32'(rdy(1)), 32'd1);
      chk("rst_after_resp", 32'(is_err(1)), 32'd0);
      @(posedge HCLK);
      #1;
      xfer(1, 1'b0, HSIZE_WORD, 32'h40, 32'h0, rd, waits, ea, en);
      chk("rst_old_value", rd, 32'h1122_3344);

      // Fill a 64-byte window, then random pipelined traffic against a byte-array model.
      for (int w = 0; w < 16; w++) begin
         d = $urandom;
         xfer(0, 1'b1, HSIZE_WORD, 32'(4 * w), d, rd, waits, ea, en);
         for (int b = 0; b < 4; b++) mm[4 * w + b] = d[8 * b +: 8];
      end
      pk     = P_NONE;
      hold   = 1'b0;
      p_wd   = 32'h0;
      p_wr   = 1'b0;
      p_off  = 0;
      p_nb   = 1;
      r_off  = 0;
      r_wd   = 32'h0;
      hburst = HBURST_INCR;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            hsel   = ($urandom_range(0, 7) != 0) ? 2'b01 : 2'b00;
            htrans = HTRANS_E'($urandom_range(0, 3));
            hwrite = 1'($urandom_range(0, 1));
            hsize  = HSIZE_E'($urandom_range(0, 3));
            r_off  = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0 && hsize != HSIZE_DWORD)
               r_off = r_off & ~((1 << int'(hsize)) - 1);
            haddr  = ($urandom & 32'hFFFF_FC00) | 32'(r_off);
            r_wd   = $urandom;
         end
         hwdata = p_wd;
         @(negedge HCLK);
         exp_rdy = (pk != P_ERR1);
         exp_e   = (pk == P_ERR1 || pk == P_ERR2);
         exp_rd  = 32'h0;
         if (pk == P_OK && !p_wr)
            for (int b = 0; b < p_nb; b++) exp_rd[8 * ((p_off + b) % 4) +: 8] = mm[p_off + b];
         chk($sformatf("rnd%0d_ready", c), 32'(rdy(0)), 32'(exp_rdy));
         chk($sformatf("rnd%0d_resp", c), 32'(is_err(0)), 32'(exp_e));
         chk($sformatf("rnd%0d_rdata", c), rdat(0), exp_rd);
         if (pk == P_OK && p_wr)
            for (int b = 0; b < p_nb; b++) mm[p_off + b] = hwdata[8 * ((p_off + b) % 4) +: 8];
         if (pk == P_ERR1) begin
            pk = P_ERR2;
         end else if (hsel[0] && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)) begin
            nb = 1 << int'(hsize);
            if (nb > 4 || (r_off % nb) != 0) begin
               pk = P_ERR1;
            end else begin
               pk    = P_OK;
               p_wr  = hwrite;
               p_off = r_off;
               p_nb  = nb;
               p_wd  = r_wd;
            end
         end else begin
            pk = P_NONE;
         end
         hold = !exp_rdy;
         @(posedge HCLK);
         #1;
      end
      idle_bus();
      @(posedge HCLK);
      #1;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
